de_selector_scan: RTL and testbench

//  Registered, parametrised 1-to-2^SEL_W demultiplexer with active-low outputs.
//  - Manual mode: the select input chooses the output.
//  - Auto mode: an internal prescaled counter rotates the selection, giving a

---
 rtl/de_selector_scan.sv | 70 +++++++
 tb/tb_de_selector_scan.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/de_selector_scan.sv
// Registered 1-to-2**SEL_W demultiplexer with active-low outputs.
// Selection comes from iS in manual mode or from a prescaled rotating counter in auto mode.
module de_selector_scan #(
    parameter int SEL_W = 2,
    parameter int DIV   = 4
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    input  logic                  iC,
    input  logic                  iMode,
    input  logic [SEL_W-1:0]      iS,
    input  logic                  iHold,
    output logic [2**SEL_W-1:0]   oZ,
    output logic [SEL_W-1:0]      oSel,
    output logic                  oWrap
);

    localparam int N  = 2 ** SEL_W;
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    logic [SEL_W-1:0] sel_q, sel_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             wrap_d;
    logic [N-1:0]     z_d;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        sel_d   = sel_q;
        presc_d = presc_q;
        wrap_d  = 1'b0;

        if (!iMode) begin
            sel_d   = iS;
            presc_d = '0;
        end else if (!iHold) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                sel_d   = sel_q + SEL_W'(1);
                wrap_d  = &sel_q;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end

        // Enable gating acts on the next-state select, so it is never frozen by iHold.
        z_d = '1;
        if (!iC) begin
            z_d[sel_d] = 1'b0;
        end
    end

    always_ff @(posedge iClk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!iRst_n) begin
            sel_q   <= '0;
            presc_q <= '0;
            oZ      <= '1;
            oWrap   <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            presc_q <= presc_d;
            oZ      <= z_d;
            oWrap   <= wrap_d;
        end
    end

    assign oSel = sel_q;

endmodule

// File: tb/tb_de_selector_scan.sv
// Self-checking bench for de_selector_scan: two instances (SEL_W=2/DIV=3 and SEL_W=3/DIV=1)
// share stimulus; a reference model pushes expected outputs that are popped after each edge.
module tb_de_selector_scan;

    typedef struct {
        int         inst;
        logic [7:0] z;
        logic [2:0] sel;
        logic       wrap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n, c, mode, hold;
    logic [2:0] s;

    logic [3:0] z_a;
    logic [1:0] sel_a;
    logic       wrap_a;
    logic [7:0] z_b;
    logic [2:0] sel_b;
    logic       wrap_b;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];
    int   m_sel[2];
    int   m_presc[2];

    always #5 clk = ~clk;

    de_selector_scan #(.SEL_W(2), .DIV(3)) dut_a (
        .iClk(clk), .iRst_n(rst_n), .iC(c), .iMode(mode), .iS(s[1:0]), .iHold(hold),
        .oZ(z_a), .oSel(sel_a), .oWrap(wrap_a)
    );

    de_selector_scan #(.SEL_W(3), .DIV(1)) dut_b (
        .iClk(clk), .iRst_n(rst_n), .iC(c), .iMode(mode), .iS(s), .iHold(hold),
        .oZ(z_b), .oSel(sel_b), .oWrap(wrap_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_step(input int i, output exp_t e);
        int n  = (i == 0) ? 4 : 8;
        int dv = (i == 0) ? 3 : 1;
        int wr = 0;
        if (!rst_n) begin
            m_sel[i]   = 0;
            m_presc[i] = 0;
        end else if (!mode) begin
            m_sel[i]   = int'(s) % n;
            m_presc[i] = 0;
        end else if (!hold) begin
            if (m_presc[i] == dv - 1) begin
                m_presc[i] = 0;
                wr         = (m_sel[i] == n - 1) ? 1 : 0;
                m_sel[i]   = (m_sel[i] + 1) % n;
            end else begin
                m_presc[i]++;
            end
        end
        e.inst = i;
        e.z    = 8'((1 << n) - 1);
        if (rst_n && !c) e.z[m_sel[i]] = 1'b0;
        e.sel  = 3'(m_sel[i]);
        e.wrap = (wr != 0);
    endtask

    // One clock: predict, advance, sample #1 after the edge, compare.
    task automatic cycle();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            model_step(i, e);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.inst == 0) begin
                check("a_z", 32'(z_a), 32'(e.z));
                check("a_sel", 32'(sel_a), 32'(e.sel));
                check("a_wrap", 32'(wrap_a), 32'(e.wrap));
            end else begin
                check("b_z", 32'(z_b), 32'(e.z));
                check("b_sel", 32'(sel_b), 32'(e.sel));
                check("b_wrap", 32'(wrap_b), 32'(e.wrap));
            end
        end
    endtask

    logic [3:0] man_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    int k;
    int wraps;

    initial begin
        m_sel   = '{0, 0};
        m_presc = '{0, 0};
        rst_n = 1'b0; c = 1'b0; mode = 1'b1; hold = 1'b0; s = '0;

        // Reset held two cycles while auto mode and enable are active.
        repeat (2) begin
            cycle();
            check("rst_z", 32'(z_a), 32'h0000000f);
            check("rst_sel", 32'(sel_a), 32'd0);
            check("rst_wrap", 32'(wrap_a), 32'd0);
        end
        rst_n = 1'b1;

        // Manual sweep.
        mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s = 3'(i);
            cycle();
            check("man_z", 32'(z_a), 32'(man_tab[i]));
        end
        c = 1'b1;
        cycle();
        check("man_off", 32'(z_a), 32'h0000000f);

        // Auto scan from sel 0.
        c = 1'b0; s = 3'd0;
        cycle();
        mode = 1'b1;
        k = 0;
        for (int t = 1; t <= 20 && k == 0; t++) begin
            cycle();
            if (t % 3 == 0 && t < 12) check("scan_sel", 32'(sel_a), 32'(t / 3));
            if (wrap_a) k = t;
        end
        check("wrap_lat", 32'(k), 32'd12);

        // Hold at sel 2 with prescaler 1.
        repeat (7) cycle();
        check("pre_hold", 32'(sel_a), 32'd2);
        hold = 1'b1;
        repeat (5) begin
            cycle();
            check("hold_sel", 32'(sel_a), 32'd2);
        end
        hold = 1'b0;
        k = 0;
        for (int t = 1; t <= 10 && k == 0; t++) begin
            cycle();
            if (sel_a == 2'd3) k = t;
        end
        check("hold_rel", 32'(k), 32'd2);

        // Mode switch auto -> manual -> auto.
        mode = 1'b0; s = 3'd1;
        cycle();
        check("to_man", 32'(sel_a), 32'd1);
        mode = 1'b1;
        k = 0;
        for (int t = 1; t <= 10 && k == 0; t++) begin
            cycle();
            if (sel_a == 2'd2) k = t;
        end
        check("to_auto", 32'(k), 32'd3);

        // DIV=1 instance: wrap once per 8 cycles, then reset mid-scan.
        wraps = 0;
        repeat (16) begin
            cycle();
            if (wrap_b) wraps++;
        end
        check("b_wraps", 32'(wraps), 32'd2);
        k = 0;
        for (int t = 1; t <= 16 && k == 0; t++) begin
            if (sel_b == 3'd5) k = t;
            else cycle();
        end
        check("b_at5", 32'(sel_b), 32'd5);
        rst_n = 1'b0;
        cycle();
        check("b_rst_sel", 32'(sel_b), 32'd0);
        check("b_rst_z", 32'(z_b), 32'h000000ff);
        rst_n = 1'b1;
        repeat (3) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
